// File: rtl/controleur_multi.sv
// Keyboard-driven multi-player position controller: decodes PS/2 scancodes into
// held-key flags and moves each player's clamped centre once per video frame.
module controleur_multi #(
    parameter int NPLAYERS = 2,
    parameter int HACTIVE  = 800,
    parameter int VACTIVE  = 600,
    parameter int STEP     = 2,
    parameter int MARGIN   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    EOF,
    input  logic [7:0]              data_out,
    input  logic                    data_valide,
    output logic [NPLAYERS*11-1:0]  centerX,
    output logic [NPLAYERS*11-1:0]  centerY,
    output logic [NPLAYERS*4-1:0]   keys_held
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXTBRK
    } ps2_state_e;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    // Key index within a player nibble: 0 right, 1 left, 2 down, 3 up.
    localparam logic [7:0] KEY_MAP [2][4] = '{
        '{8'h23, 8'h1C, 8'h1B, 8'h1D},
        '{8'h4B, 8'h3B, 8'h42, 8'h43}
    };

    localparam logic signed [11:0] STEP12 = 12'(STEP);
    localparam logic signed [11:0] X_MIN  = 12'(MARGIN);
    localparam logic signed [11:0] X_MAX  = 12'(HACTIVE - 1 - MARGIN);
    localparam logic signed [11:0] Y_MIN  = 12'(MARGIN);
    localparam logic signed [11:0] Y_MAX  = 12'(VACTIVE - 1 - MARGIN);

    ps2_state_e              state_q, state_d;
    logic                    is_make, is_break;
    logic [NPLAYERS*4-1:0]   keys_q, keys_d;
    logic                    eof_q;
    logic                    frame_tick;

    // ------------------------------------------------------------------
    // Scancode FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred.
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        if (data_valide) begin
            unique case (state_q)
                S_IDLE: begin
                    if (data_out == CODE_BRK) begin
                        state_d = S_BRK;
                    end else if (data_out == CODE_EXT) begin
                        state_d = S_EXT;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                S_BRK: begin
                    is_break = 1'b1;
                    state_d  = S_IDLE;
                end
                S_EXT: begin
                    state_d = (data_out == CODE_BRK) ? S_EXTBRK : S_IDLE;
                end
                S_EXTBRK: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Held-key flags
    // ------------------------------------------------------------------
    always_comb begin
        keys_d = keys_q;
        for (int p = 0; p < NPLAYERS; p++) begin
            for (int k = 0; k < 4; k++) begin
                if ((is_make || is_break) && (data_out == KEY_MAP[p][k])) begin
                    keys_d[p*4 + k] = is_make;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            keys_q <= '0;
            eof_q  <= 1'b0;
        end else begin
            keys_q <= keys_d;
            eof_q  <= EOF;
        end
    end

    // Moves read keys_q, so a byte landing on the tick cycle only counts next frame.
    assign frame_tick = EOF & ~eof_q;
    assign keys_held  = keys_q;

    function automatic logic signed [10:0] step_axis(
        input logic signed [10:0] pos,
        input logic               pos_key,
        input logic               neg_key,
        input logic signed [11:0] lo,
        input logic signed [11:0] hi
    );
        logic signed [11:0] cand;
        cand = {pos[10], pos};
        if (pos_key && !neg_key) begin
            cand = cand + STEP12;
        end else if (neg_key && !pos_key) begin
            cand = cand - STEP12;
        end
        if (cand < lo) begin
            cand = lo;
        end else if (cand > hi) begin
            cand = hi;
        end
        return cand[10:0];
    endfunction

    // ------------------------------------------------------------------
    // Per-player position registers
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        localparam logic signed [10:0] X_INIT =
            (p == 0) ? 11'(HACTIVE / 4) : 11'(3 * HACTIVE / 4);
        localparam logic signed [10:0] Y_INIT = 11'(VACTIVE / 2);

        logic signed [10:0] x_q, x_d;
        logic signed [10:0] y_q, y_d;

        always_comb begin
            x_d = x_q;
            y_d = y_q;
            if (frame_tick) begin
                x_d = step_axis(x_q, keys_q[p*4 + 0], keys_q[p*4 + 1], X_MIN, X_MAX);
                y_d = step_axis(y_q, keys_q[p*4 + 2], keys_q[p*4 + 3], Y_MIN, Y_MAX);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                x_q <= X_INIT;
                y_q <= Y_INIT;
            end else begin
                x_q <= x_d;
                y_q <= y_d;
            end
        end

        assign centerX[p*11 +: 11] = x_q;
        assign centerY[p*11 +: 11] = y_q;
    end

endmodule

// File: tb/tb_controleur_multi.sv
// Scoreboard bench for controleur_multi: directed scancode/EOF sequences with
// hand-computed expected centres and held keys.
module tb_controleur_multi;

    logic        clk;
    logic        reset_n;
    logic        EOF;
    logic [7:0]  data_out;
    logic        data_valide;
    logic [21:0] centerX;
    logic [21:0] centerY;
    logic [7:0]  keys_held;

    typedef struct {
        string       name;
        logic [21:0] cx;
        logic [21:0] cy;
        logic [7:0]  keys;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    controleur_multi #(
        .NPLAYERS(2), .HACTIVE(800), .VACTIVE(600), .STEP(2), .MARGIN(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .EOF        (EOF),
        .data_out   (data_out),
        .data_valide(data_valide),
        .centerX    (centerX),
        .centerY    (centerY),
        .keys_held  (keys_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares outputs against every queued expectation at a negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if (centerX !== e.cx || centerY !== e.cy || keys_held !== e.keys) begin
                    tests_failed++;
                    $display("FAIL %s: got cx=%h cy=%h keys=%h, want cx=%h cy=%h keys=%h",
                             e.name, centerX, centerY, keys_held, e.cx, e.cy, e.keys);
                end
            end
        end
    end

    task automatic expect_state(input string name, input int x0, input int y0,
                                input int x1, input int y1, input logic [7:0] keys);
        exp_t e;
        int   budget;
        e.name = name;
        e.cx   = {11'(x1), 11'(x0)};
        e.cy   = {11'(y1), 11'(y0)};
        e.keys = keys;
        sb.push_back(e);
        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: monitor did not consume expectation", name);
            sb.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_out    = b;
        data_valide = 1'b1;
        @(negedge clk);
        data_valide = 1'b0;
    endtask

    task automatic eof_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            EOF = 1'b1;
            @(negedge clk);
            EOF = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n     = 1'b1;
        EOF         = 1'b0;
        data_out    = 8'h00;
        data_valide = 1'b0;
        do_reset();
        expect_state("reset", 200, 300, 600, 300, 8'h00);

        send_byte(8'h1D);
        send_byte(8'h23);
        expect_state("make_w_d", 200, 300, 600, 300, 8'h09);
        eof_pulses(3);
        expect_state("diag_3_frames", 206, 294, 600, 300, 8'h09);

        send_byte(8'hF0); send_byte(8'h23);
        expect_state("break_d", 206, 294, 600, 300, 8'h08);
        eof_pulses(1);
        expect_state("up_only", 206, 292, 600, 300, 8'h08);

        send_byte(8'hF0); send_byte(8'h1D);
        send_byte(8'h1C);
        send_byte(8'h4B);
        expect_state("hold_a_l", 206, 292, 600, 300, 8'h12);
        eof_pulses(200);
        expect_state("clamp_lo_hi", 16, 292, 783, 300, 8'h12);
        eof_pulses(1);
        expect_state("clamp_stays", 16, 292, 783, 300, 8'h12);

        send_byte(8'hF0); send_byte(8'h4B);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'h23);
        eof_pulses(1);
        expect_state("off_wall", 18, 292, 783, 300, 8'h01);
        send_byte(8'h1C);
        eof_pulses(1);
        expect_state("both_lr", 18, 292, 783, 300, 8'h03);

        send_byte(8'hF0); send_byte(8'h1C);
        @(negedge clk);
        EOF = 1'b1;
        repeat (10) @(negedge clk);
        EOF = 1'b0;
        @(negedge clk);
        expect_state("eof_level", 20, 292, 783, 300, 8'h01);

        send_byte(8'hF0); send_byte(8'h23);
        @(negedge clk);
        EOF         = 1'b1;
        data_out    = 8'h23;
        data_valide = 1'b1;
        @(negedge clk);
        EOF         = 1'b0;
        data_valide = 1'b0;
        @(negedge clk);
        expect_state("byte_on_tick", 20, 292, 783, 300, 8'h01);
        eof_pulses(1);
        expect_state("byte_next_frame", 22, 292, 783, 300, 8'h01);

        send_byte(8'hE0); send_byte(8'h1D);
        expect_state("ext_make_ignored", 22, 292, 783, 300, 8'h01);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h23);
        expect_state("ext_break_ignored", 22, 292, 783, 300, 8'h01);
        send_byte(8'h15);
        expect_state("unmapped", 22, 292, 783, 300, 8'h01);

        send_byte(8'hF0);
        do_reset();
        expect_state("reset_mid_seq", 200, 300, 600, 300, 8'h00);
        send_byte(8'h1D);
        expect_state("make_after_reset", 200, 300, 600, 300, 8'h08);

        send_byte(8'h42);
        eof_pulses(1);
        expect_state("p1_down", 200, 298, 600, 302, 8'h48);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/controleur_multi.md
CONTROLEUR_MULTI -- requirements
Module: controleur_multi

Interface
REQ-001 The block SHALL have parameter NPLAYERS, default 2, meaning the number of controlled players (legal 1..2).
REQ-002 The block SHALL have parameter HACTIVE, default 800, meaning the horizontal active size in pixels.
REQ-003 The block SHALL have parameter VACTIVE, default 600, meaning the vertical active size in pixels.
REQ-004 The block SHALL have parameter STEP, default 2, meaning the pixels moved per frame per axis (legal 1..15).
REQ-005 The block SHALL have parameter MARGIN, default 16, meaning the minimum distance from a centre to any screen edge.
REQ-006 The block SHALL have the port clk, input, 1, meaning the single system clock.
REQ-007 The block SHALL have the port reset_n, input, 1, meaning the asynchronous active-low reset.
REQ-008 The block SHALL have the port EOF, input, 1, meaning the end-of-frame level from the video timing block.
REQ-009 The block SHALL have the port data_out, input, 8, meaning a PS/2 scancode byte.
REQ-010 The block SHALL have the port data_valide, input, 1, meaning data_out is valid this cycle (one-cycle strobe).
REQ-011 The block SHALL have the port centerX, output, NPLAYERS*11, meaning the signed X centres, with player p in bits [11p+10:11p].
REQ-012 The block SHALL have the port centerY, output, NPLAYERS*11, meaning the signed Y centres, with the same packing as centerX.
REQ-013 The block SHALL have the port keys_held, output, NPLAYERS*4, meaning the held keys per player as {up,down,left,right}.

Function
REQ-014 The block SHALL decode scancodes with a four-state FSM: IDLE, BRK (after F0), EXT (after E0) and EXTBRK (after E0 F0).
REQ-015 The FSM SHALL advance only on cycles where data_valide=1; with data_valide=0 it SHALL hold its state.
REQ-016 In IDLE, F0 SHALL go to BRK, E0 SHALL go to EXT, and any other byte SHALL be a make code that stays in IDLE.
REQ-017 In BRK, any byte SHALL be a break code, and the FSM SHALL return to IDLE.
REQ-018 In EXT, F0 SHALL go to EXTBRK; any other byte SHALL be ignored, and the FSM SHALL return to IDLE.
REQ-019 In EXTBRK, any byte SHALL be ignored, and the FSM SHALL return to IDLE.
REQ-020 The key map SHALL be: player 0 up/down/left/right = 1D/1B/1C/23 (W/S/A/D); player 1 = 43/42/3B/4B (I/K/J/L).
REQ-021 A make code of a mapped key SHALL set its keys_held bit on the next clock edge.
REQ-022 A break code of a mapped key SHALL clear its keys_held bit on the next clock edge.
REQ-023 Unmapped codes SHALL be ignored, and the keys of players at index NPLAYERS or above SHALL be ignored.
REQ-024 The block SHALL register EOF, and a frame tick SHALL be the single cycle where EOF=1 and the registered EOF=0 (rising edge).
REQ-025 On a frame tick, each player axis SHALL move +STEP if only the positive key is held, -STEP if only the negative key is held, and SHALL NOT move if both or neither key is held.
REQ-026 Right and down SHALL be positive.
REQ-027 X and Y SHALL update independently, so a diagonal move applies both axes in the same tick.
REQ-028 The block SHALL compute the candidate position in 12-bit signed arithmetic.
REQ-029 The candidate position SHALL then be clamped to [MARGIN, HACTIVE-1-MARGIN] for X and [MARGIN, VACTIVE-1-MARGIN] for Y, and SHALL never wrap.
REQ-030 Position SHALL update exactly once per frame tick, and an EOF held high for many cycles SHALL produce one move.
REQ-031 If data_valide and a frame tick coincide, the move SHALL use keys_held as it was before that byte, and the byte SHALL take effect from the next frame.
REQ-032 Outputs SHALL be registered, with the new centre visible one cycle after the frame tick.

Reset
REQ-033 Asynchronous reset_n=0 SHALL immediately force the FSM to IDLE, keys_held=0 and the registered EOF=0.
REQ-034 Asynchronous reset_n=0 SHALL immediately force player 0 to (HACTIVE/4, VACTIVE/2)=(200,300) and player 1 to (3*HACTIVE/4, VACTIVE/2)=(600,300).
REQ-035 A reset mid-sequence, such as after F0, SHALL discard the partial sequence.
REQ-036 After release, the block SHALL act on the first data_valide or EOF edge with no extra latency.

Verification
REQ-037 Reset, then send 1D and 23, then 3 EOF pulses (STEP=2) -> player 0 = (206,294); keys_held[3:0]=1001.
REQ-038 Send F0 23, then 1 EOF pulse -> player 0 moves only in Y by -2; keys_held[0]=0.
REQ-039 Hold 1C for 200 frames from X=200 -> X stops at 16 and stays; hold 4B for player 1 -> X saturates at 783.
REQ-040 Send 1C and 23 (both held), then an EOF pulse -> X unchanged.
REQ-041 Send E0 1D and E0 F0 1D -> keys_held unchanged; send F0 then assert reset_n=0, then send 1D -> 1D treated as make.
REQ-042 Hold EOF high 10 cycles with 23 held -> X advances by exactly 2.
REQ-043 data_valide with 23 in the same cycle as the EOF rising edge -> no move that frame, +2 on the next.
